fpu_issue_queue: RTL and testbench

FPU_ISSUE_QUEUE -- requirements
Module: fpu_issue_queue

---
 rtl/fpu_issue_queue.sv | 106 ++++++++++
 tb/tb_fpu_issue_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_queue.sv
// In-order issue queue between the FPU decode stage and the FPU interconnect.
// Circular buffer with head/tail pointers and a separate occupancy counter;
// no bypass path, so an accepted instruction reaches out_msg one cycle later
// at the earliest. flash discards every entry; reset wins over everything.

package fpu_issue_pkg;

    // Decoded FPU instruction as carried through the issue queue.
    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [3:0] rob_tag;
    } FpuInstr;

endpackage

module fpu_issue_queue #(
    // Number of entries; must be a power of two in 2..16 so the pointers wrap
    // naturally on overflow.
    parameter int DEPTH = 4,
    parameter int W     = $bits(fpu_issue_pkg::FpuInstr)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flash,
    input  logic                   in_en,
    input  logic [W-1:0]           in_msg,
    output logic                   in_reject,
    output logic                   out_en,
    output logic [W-1:0]           out_msg,
    input  logic                   out_reject,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic enq;
    logic deq;

    // in_reject looks only at registered occupancy and flash, never at a
    // same-cycle dequeue, so a full queue refuses even while it drains.
    assign full      = (count_q == CW'(DEPTH));
    assign in_reject = full | flash;
    assign out_en    = (count_q != '0) & ~flash;
    assign out_msg   = mem_q[head_q];
    assign count     = count_q;

    assign enq = in_en & ~in_reject;
    assign deq = out_en & ~out_reject;

    // Next-state for pointers and occupancy; flash clears, otherwise each
    // side advances on its own handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + 1'b1;
            if (deq) head_d = head_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload RAM write at tail on an accepted enqueue.
    always_ff @(posedge clock) begin
        // NOTE: the RAM is deliberately not reset; stale entries are unreachable once the pointers and count are cleared.
        if (enq && !reset) begin
            mem_q[tail_q] <= in_msg;
        end
    end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue (DEPTH=4). A driver applies
// directed and random stimulus, checks the control outputs against a
// reference occupancy model, and pushes every accepted payload into a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT completes an output transfer.

module tb_fpu_issue_queue;

    localparam int DEPTH = 4;
    localparam int W     = $bits(fpu_issue_pkg::FpuInstr);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flash = 1'b0;
    logic          in_en = 1'b0;
    logic [W-1:0]  in_msg = '0;
    logic          in_reject;
    logic          out_en;
    logic [W-1:0]  out_msg;
    logic          out_reject = 1'b0;
    logic [CW-1:0] count;

    fpu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .flash      (flash),
        .in_en      (in_en),
        .in_msg     (in_msg),
        .in_reject  (in_reject),
        .out_en     (out_en),
        .out_msg    (out_msg),
        .out_reject (out_reject),
        .count      (count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue contents in order, plus occupancy.
    logic [W-1:0] sb_q[$];
    int           model_cnt = 0;
    bit           known     = 1'b0;
    bit           last_acc  = 1'b0;
    int           max_seen  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, check the
    // registered-state outputs, then advance the reference model.
    task automatic cycle(input logic en, input logic [W-1:0] msg, input logic fl,
                         input logic orej, input logic rst);
        bit exp_in_rej;
        bit exp_out_en;
        bit acc;
        bit deq;
        @(negedge clock);
        in_en      = en;
        in_msg     = msg;
        flash      = fl;
        out_reject = orej;
        reset      = rst;
        #1;
        exp_in_rej = fl || (model_cnt == DEPTH);
        exp_out_en = (model_cnt != 0) && !fl;
        if (known) begin
            check("count",     64'(count),     64'(model_cnt));
            check("in_reject", 64'(in_reject), 64'(exp_in_rej));
            check("out_en",    64'(out_en),    64'(exp_out_en));
            if (model_cnt > max_seen) max_seen = model_cnt;
        end
        acc = en && !exp_in_rej;
        deq = exp_out_en && !orej;
        if (rst) begin
            model_cnt = 0;
            sb_q.delete();
            known = 1'b1;
        end else if (fl) begin
            model_cnt = 0;
            sb_q.delete();
        end else begin
            if (acc) sb_q.push_back(msg);
            model_cnt = model_cnt + int'(acc) - int'(deq);
        end
        last_acc = acc && !rst;
    endtask

    // Offer one item until accepted; mode 0/1 fixes out_reject, 2 randomises it.
    task automatic send(input logic [W-1:0] msg, input int mode);
        int  n = 0;
        logic orej;
        do begin
            orej = (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode);
            cycle(1'b1, msg, 1'b0, orej, 1'b0);
            n++;
        end while (!last_acc && n < 64);
        check("send_accept", 64'(last_acc), 64'd1);
    endtask

    task automatic idle(input int n, input logic orej);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, orej, 1'b0);
    endtask

    // Monitor: compares every completed output transfer against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset !== 1'b1 && out_en === 1'b1 && out_reject === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 64'(out_msg), 64'd0 - 64'd1);
                end else begin
                    check("out_msg", 64'(out_msg), 64'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] held;

        // Reset: first cycle has unknown state, second is checked.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Fill/drain: A..D accepted under backpressure, E held, then released.
        for (int i = 0; i < 4; i++) send(W'(32'hA0 + i), 1);
        cycle(1'b1, W'(32'hE0), 1'b0, 1'b1, 1'b0);
        check("full_holds_e", 64'(last_acc), 64'd0);
        cycle(1'b1, W'(32'hE0), 1'b0, 1'b0, 1'b0);
        check("full_deq_rejects_e", 64'(last_acc), 64'd0);
        send(W'(32'hE0), 0);
        idle(6, 1'b0);

        // Concurrent: hold two entries while streaming ten more through.
        send(W'($urandom), 1);
        send(W'($urandom), 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
            check("concurrent_cnt", 64'(model_cnt), 64'd2);
        end
        idle(4, 1'b0);

        // Wrap-around: eleven items under random backpressure.
        max_seen = 0;
        for (int i = 0; i < 11; i++) send(W'($urandom), 2);
        idle(8, 1'b0);
        check("max_count_le_depth", 64'(max_seen <= DEPTH), 64'd1);

        // Flash with simultaneous offer and ready consumer.
        for (int i = 0; i < 3; i++) send(W'($urandom), 1);
        cycle(1'b1, W'($urandom), 1'b1, 1'b0, 1'b0);
        check("flash_no_accept", 64'(last_acc), 64'd0);
        idle(2, 1'b0);

        // Reset mid-operation with a full queue.
        for (int i = 0; i < 4; i++) send(W'($urandom), 1);
        cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Stability: one entry held under backpressure for five cycles.
        held = W'($urandom);
        send(held, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
            check("hold_out_msg", 64'(out_msg), 64'(held));
            check("hold_out_en",  64'(out_en),  64'd1);
        end
        idle(2, 1'b0);

        // Random traffic with occasional flash and reset.
        for (int i = 0; i < 400; i++) begin
            cycle(logic'($urandom_range(0, 1)), W'($urandom),
                  logic'($urandom_range(0, 39) == 0),
                  logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 99) == 0));
        end

        // Drain and confirm nothing was lost.
        idle(8, 1'b0);
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
